// File: rtl/md5_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md5_acc_pkg
// Description : Shared widths and constants for the MD5 accelerator blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package md5_acc_pkg;

    localparam int MD5_DIGEST_W = 128;
    localparam int CAND_W       = 31;

    // Match counter width and the value at which it saturates.
    localparam int                     MATCH_CNT_W   = 8;
    localparam logic [MATCH_CNT_W-1:0] MATCH_CNT_MAX = {MATCH_CNT_W{1'b1}};

endpackage : md5_acc_pkg
`default_nettype wire

// File: rtl/md5_match_tracker_if.sv
`default_nettype none
// ============================================================================
// Module      : md5_match_tracker_if
// Description : Candidate/digest/status bundle between the counter, core and tracker.
// Revision    : 1.0 - initial release
// ============================================================================
interface md5_match_tracker_if #(
    parameter int CAND_W   = 31,
    parameter int DIGEST_W = 128,
    parameter int DEPTH    = 8,
    parameter int CNT_W    = 8
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic                clear;
    logic [DIGEST_W-1:0] target;
    logic                cand_valid;
    logic [CAND_W-1:0]   cand_value;
    logic                counter_done;
    logic                digest_valid;
    logic [DIGEST_W-1:0] digest;

    logic                cand_stall;
    logic                found;
    logic [CAND_W-1:0]   match_value;
    logic [CNT_W-1:0]    match_count;
    logic                search_complete;
    logic                drop_err;
    logic                underflow_err;
    logic [LVL_W-1:0]    fifo_level;

    modport master (
        output clear, target, cand_valid, cand_value, counter_done, digest_valid, digest,
        input  cand_stall, found, match_value, match_count, search_complete,
               drop_err, underflow_err, fifo_level
    );

    modport slave (
        input  clear, target, cand_valid, cand_value, counter_done, digest_valid, digest,
        output cand_stall, found, match_value, match_count, search_complete,
               drop_err, underflow_err, fifo_level
    );

endinterface : md5_match_tracker_if
`default_nettype wire

// File: rtl/md5_match_tracker_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tag_fifo
// Description : Synchronous tag FIFO with occupancy, full and empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tag_fifo #(
    parameter int WIDTH = 31,
    parameter int DEPTH = 8
) (
    input  wire logic                     CLK,
    input  wire logic                     reset,
    input  wire logic                     clr,
    input  wire logic                     push,
    input  wire logic                     pop,
    input  wire logic [WIDTH-1:0]         wdata,
    output logic      [WIDTH-1:0]         rdata,
    output logic      [$clog2(DEPTH):0]   level,
    output logic                          full,
    output logic                          empty
);
    localparam int                   c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]     c_depth = (c_ptr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_level;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once the level covers them.
    always_ff @(posedge CLK) begin
        if (push) r_mem[r_wr_ptr] <= wdata;
    end

    assign rdata = r_mem[r_rd_ptr];
    assign level = r_level;
    assign full  = (r_level == c_depth);
    assign empty = (r_level == '0);

endmodule : tag_fifo
`default_nettype wire

// File: rtl/md5_match_tracker.sv
`default_nettype none
// ============================================================================
// Module      : md5_match_tracker
// Description : Pairs issued candidates with returned digests and latches the first match.
// Revision    : 1.0 - initial release
// ============================================================================
module md5_match_tracker #(
    parameter int CAND_W   = md5_acc_pkg::CAND_W,
    parameter int DIGEST_W = md5_acc_pkg::MD5_DIGEST_W,
    parameter int DEPTH    = 8,
    parameter int CNT_W    = md5_acc_pkg::MATCH_CNT_W
) (
    input wire logic          CLK,
    input wire logic          reset,
    md5_match_tracker_if.slave bus
);
    import md5_acc_pkg::*;

    localparam int               c_lvl_w   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_hit;
    logic [CAND_W-1:0]  w_head;
    logic [c_lvl_w-1:0] w_level;

    logic                r_stg_valid;
    logic [CAND_W-1:0]   r_stg_tag;
    logic [DIGEST_W-1:0] r_stg_digest;
    logic                r_found;
    logic [CAND_W-1:0]   r_match_value;
    logic [CNT_W-1:0]    r_match_count;
    logic                r_complete;
    logic                r_drop_err;
    logic                r_underflow_err;

    // Pop is judged on registered occupancy, so a same-cycle push never feeds a pop.
    assign w_pop  = bus.digest_valid && !w_empty;
    assign w_push = bus.cand_valid && (!w_full || w_pop);
    assign w_hit  = r_stg_valid && (r_stg_digest == bus.target);

    tag_fifo #(
        .WIDTH (CAND_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .CLK   (CLK),
        .reset (reset),
        .clr   (bus.clear),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (bus.cand_value),
        .rdata (w_head),
        .level (w_level),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_stg_valid  <= 1'b0;
            r_stg_tag    <= '0;
            r_stg_digest <= '0;
        end else if (bus.clear) begin
            r_stg_valid  <= 1'b0;
            r_stg_tag    <= '0;
            r_stg_digest <= '0;
        end else begin
            r_stg_valid <= w_pop;
            if (w_pop) begin
                r_stg_tag    <= w_head;
                r_stg_digest <= bus.digest;
            end
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_found         <= 1'b0;
            r_match_value   <= '0;
            r_match_count   <= '0;
            r_complete      <= 1'b0;
            r_drop_err      <= 1'b0;
            r_underflow_err <= 1'b0;
        end else if (bus.clear) begin
            r_found         <= 1'b0;
            r_match_value   <= '0;
            r_match_count   <= '0;
            r_complete      <= 1'b0;
            r_drop_err      <= 1'b0;
            r_underflow_err <= 1'b0;
        end else begin
            if (w_hit) begin
                if (!r_found) begin
                    r_found       <= 1'b1;
                    r_match_value <= r_stg_tag;
                end
                if (r_match_count != c_cnt_max) r_match_count <= r_match_count + 1'b1;
            end
            if (bus.cand_valid && !w_push)   r_drop_err      <= 1'b1;
            if (bus.digest_valid && !w_pop)  r_underflow_err <= 1'b1;
            // Completion waits for every queued tag to clear the compare stage.
            if (bus.counter_done && w_empty && !r_stg_valid && !w_pop) r_complete <= 1'b1;
        end
    end

    assign bus.cand_stall      = w_full;
    assign bus.found           = r_found;
    assign bus.match_value     = r_match_value;
    assign bus.match_count     = r_match_count;
    assign bus.search_complete = r_complete;
    assign bus.drop_err        = r_drop_err;
    assign bus.underflow_err   = r_underflow_err;
    assign bus.fifo_level      = w_level;

endmodule : md5_match_tracker
`default_nettype wire

// File: doc/md5_match_tracker.md
Name: md5_match_tracker

Overview:
- Downstream consumer of the candidate counter in the MD5 accelerator.
- Queues each 31-bit candidate value as it is issued to the MD5 core, and pairs it in order with the digest the core returns after its pipeline latency.
- Compares each digest against a 128-bit target and latches the first matching candidate.
- Back-pressures the counter when the tag queue is full, and reports when the search space is exhausted with no work outstanding.

Parameters:
- CAND_W, 31: candidate value width; matches the counter output.
- DIGEST_W, 128: MD5 digest width.
- DEPTH, 8: tag FIFO depth; power of two, at least 2, and at least the MD5 core's maximum in-flight count.
- CNT_W, 8: width of the saturating match counter.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear; same effect as reset, applied on the clock edge.
- target  in  DIGEST_W  digest to search for; must be held stable while a search runs.
- cand_valid  in  1  candidate issued to the MD5 core this cycle.
- cand_value  in  CAND_W  candidate value from the counter.
- counter_done  in  1  counter has reached its terminal value.
- digest_valid  in  1  MD5 core presents a digest this cycle.
- digest  in  DIGEST_W  digest; in-order with respect to the candidates.
- cand_stall  out  1  tag FIFO full; counter must hold (drives the counter's enable low).
- found  out  1  sticky; a match has been seen.
- match_value  out  CAND_W  candidate belonging to the first match.
- match_count  out  CNT_W  number of matches, saturating.
- search_complete  out  1  counter_done, FIFO empty and compare stage idle.
- drop_err  out  1  sticky; a candidate was lost because the FIFO was full.
- underflow_err  out  1  sticky; a digest arrived while the FIFO was empty.
- fifo_level  out  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset values: all outputs 0; FIFO pointers 0; compare stage invalid. Reset asserted mid-search discards all queued tags immediately.
- clear has identical effect on the next edge and takes priority over every other event in that cycle.
- Push:
  - A candidate is pushed when cand_valid && (level < DEPTH || pop).
  - A push while full with no pop in the same cycle sets drop_err; the FIFO is unchanged.
- Pop:
  - Occurs when digest_valid && level > 0.
  - The head tag and the digest are registered into the compare stage (stage valid = 1).
  - digest_valid with level == 0 (and no pop) sets underflow_err; the digest is ignored.
  - A push and a pop in the same cycle leave level unchanged.
  - The FIFO is never read and written through the same entry combinationally. A push to an empty FIFO is not visible to a pop in that same cycle, so underflow_err is set.
- Compare stage: one cycle after the pop, if the stage is valid and the stage digest == target:
  - If found == 0: set found = 1 and match_value = stage tag.
  - match_count increments; it saturates at 2^CNT_W-1 and does not wrap.
  - Later matches never overwrite match_value.
- Latency: digest_valid at cycle N → found and match_value visible at cycle N+2 (pop register, then compare register).
- cand_stall = (level == DEPTH), decoded from registered state only; no combinational path from any input.
- search_complete = counter_done && level == 0 && stage invalid && no pop this cycle. It is registered and falls only on reset or clear.
- Pointers wrap modulo DEPTH. level ranges 0 to DEPTH inclusive.

Decomposition:
- Shared package md5_acc_pkg holds:
  - MD5_DIGEST_W = 128
  - CAND_W = 31
  - the match-counter saturation constant
- Natural sub-module: tag_fifo (a synchronous FIFO with level, full and empty outputs, and async reset), instantiated once. Comparison, sticky flags and completion logic stay in the top level.

Test Plan:
- Basic match: target = digest D. Push tags 5, 6, 7, then return digests X, D, Y → found = 1 and match_value = 6 two cycles after D's digest_valid; match_count = 1; level returns to 0.
- Multiple matches: digests D, D, D for tags 10, 11, 12 → match_value stays 10; match_count = 3. Force 300 matches with CNT_W = 8 → count holds at 255.
- Full / backpressure (DEPTH = 8):
  - Push 8 tags with no digests → cand_stall = 1 and level = 8.
  - A 9th cand_valid → drop_err = 1 and level = 8.
  - A simultaneous push and pop at full → accepted, level stays 8, no drop_err.
- Underflow: digest_valid with the FIFO empty → underflow_err = 1, found unchanged. Same case with a simultaneous push → underflow_err = 1 and level = 1.
- Completion:
  - counter_done = 1 while 3 tags are outstanding → search_complete stays 0.
  - After the 3rd digest and its compare cycle → search_complete = 1.
  - clear → all outputs 0 on the next edge.
- Async reset mid-search: assert reset between clock edges with level = 5 and found = 1 → every output is 0 before the next edge; the first push after release lands at the head.
